ws2812_rx: RTL and testbench

- Single-wire WS2812 NRZ receiver; the receiving end of the protocol our WS2812 transmitter drives.
- Behaves like one pixel in a daisy chain:
  - decodes the first 24-bit word of each frame and presents it as a colour;
  - regenerates all later bits on o_Dout for downstream pixels;
  - flags the frame latch (reset gap) and timing errors.
- Used as an on-chip loopback checker for the LED path and as an input stage when the FPGA sits mid-chain.

---
 rtl/ws2812_rx.sv | 194 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver acting as one pixel in a chain: captures the
// first 24-bit word of a frame, forwards the rest, flags latch gaps and errors.
module ws2812_rx #(
  parameter int T_MIN_HIGH = 8,
  parameter int T_THRESH   = 28,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = 2400
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_Din,
  output logic [23:0] o_Colour,
  output logic        o_Valid,
  output logic        o_Dout,
  output logic        o_Latch,
  output logic        o_Error,
  output logic        o_Busy
);

  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] L_MIN      = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] L_THRESH   = CW'(T_THRESH);
  localparam logic [CW-1:0] L_MAX      = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] L_RESET    = CW'(T_RESET);
  localparam logic [CW-1:0] L_RESET_M1 = CW'(T_RESET - 1);

  typedef enum logic [2:0] {
    S_WAIT_GAP,
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_FORWARD
  } state_t;

  state_t r_State, w_NextState;

  logic          r_Sync1, r_Sync2, r_DinPrev;
  logic [CW-1:0] r_Cnt, w_NextCnt, w_CntInc;
  logic [4:0]    r_Bitcnt, w_NextBitcnt;
  logic [23:0]   r_Shreg, w_NextShreg;
  logic          r_WordReady, w_NextWordReady;
  logic          r_Dout, w_NextDout;
  logic          r_Latch, w_NextLatch;
  logic          r_Error, w_NextError;
  logic          r_Valid;
  logic [23:0]   r_Colour;
  logic          w_DinS, w_Rise, w_Fall, w_Bit;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_Sync1   <= 1'b0;
      r_Sync2   <= 1'b0;
      r_DinPrev <= 1'b0;
    end else begin
      r_Sync1   <= i_Din;
      r_Sync2   <= r_Sync1;
      r_DinPrev <= r_Sync2;
    end
  end

  assign w_DinS   = r_Sync2;
  assign w_Rise   = r_Sync2 & ~r_DinPrev;
  assign w_Fall   = ~r_Sync2 & r_DinPrev;
  assign w_Bit    = (r_Cnt >= L_THRESH);
  assign w_CntInc = (r_Cnt == L_RESET) ? r_Cnt : r_Cnt + 1'b1;

  // Low runs start counting at 1 on the falling-edge cycle so a gap ends exactly T_RESET cycles after din_s drops
  always_comb begin
    w_NextState     = r_State;
    w_NextCnt       = r_Cnt;
    w_NextBitcnt    = r_Bitcnt;
    w_NextShreg     = r_Shreg;
    w_NextWordReady = 1'b0;
    w_NextDout      = 1'b0;
    w_NextLatch     = 1'b0;
    w_NextError     = 1'b0;
    case (r_State)
      S_WAIT_GAP: begin
        if (w_DinS) begin
          w_NextCnt = '0;
        end else if (r_Cnt >= L_RESET_M1) begin
          w_NextCnt   = L_RESET;
          w_NextState = S_IDLE;
        end else begin
          w_NextCnt = w_CntInc;
        end
      end
      S_IDLE: begin
        if (w_Rise) begin
          w_NextCnt   = '0;
          w_NextState = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_Cnt > L_MAX) begin
          w_NextError  = 1'b1;
          w_NextBitcnt = '0;
          w_NextCnt    = '0;
          w_NextState  = S_WAIT_GAP;
        end else if (w_Fall) begin
          if (r_Cnt < L_MIN) begin
            w_NextError  = 1'b1;
            w_NextBitcnt = '0;
            w_NextCnt    = '0;
            w_NextState  = S_WAIT_GAP;
          end else begin
            w_NextShreg = {r_Shreg[22:0], w_Bit};
            w_NextCnt   = {{(CW-1){1'b0}}, 1'b1};
            if (r_Bitcnt == 5'd23) begin
              w_NextWordReady = 1'b1;
              w_NextBitcnt    = '0;
              w_NextState     = S_FORWARD;
            end else begin
              w_NextBitcnt = r_Bitcnt + 5'd1;
              w_NextState  = S_LOW;
            end
          end
        end else if (w_DinS) begin
          w_NextCnt = w_CntInc;
        end
      end
      S_LOW: begin
        if (w_Rise) begin
          w_NextCnt   = '0;
          w_NextState = S_HIGH;
        end else if (r_Cnt >= L_RESET_M1) begin
          w_NextLatch  = 1'b1;
          w_NextError  = (r_Bitcnt != 5'd0);
          w_NextBitcnt = '0;
          w_NextCnt    = L_RESET;
          w_NextState  = S_IDLE;
        end else begin
          w_NextCnt = w_CntInc;
        end
      end
      S_FORWARD: begin
        w_NextDout = w_DinS;
        if (w_DinS) begin
          w_NextCnt = '0;
        end else if (r_Cnt >= L_RESET_M1) begin
          w_NextLatch = 1'b1;
          w_NextDout  = 1'b0;
          w_NextCnt   = L_RESET;
          w_NextState = S_IDLE;
        end else begin
          w_NextCnt = w_CntInc;
        end
      end
      default: begin
        w_NextCnt    = '0;
        w_NextBitcnt = '0;
        w_NextState  = S_WAIT_GAP;
      end
    endcase
  end

  // State, counters and registered outputs; the colour lands one cycle after the last bit
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_State     <= S_WAIT_GAP;
      r_Cnt       <= '0;
      r_Bitcnt    <= '0;
      r_Shreg     <= '0;
      r_WordReady <= 1'b0;
      r_Dout      <= 1'b0;
      r_Latch     <= 1'b0;
      r_Error     <= 1'b0;
      r_Valid     <= 1'b0;
      r_Colour    <= '0;
    end else begin
      r_State     <= w_NextState;
      r_Cnt       <= w_NextCnt;
      r_Bitcnt    <= w_NextBitcnt;
      r_Shreg     <= w_NextShreg;
      r_WordReady <= w_NextWordReady;
      r_Dout      <= w_NextDout;
      r_Latch     <= w_NextLatch;
      r_Error     <= w_NextError;
      r_Valid     <= r_WordReady;
      if (r_WordReady) begin
        r_Colour <= r_Shreg;
      end
    end
  end

  assign o_Colour = r_Colour;
  assign o_Valid  = r_Valid;
  assign o_Dout   = r_Dout;
  assign o_Latch  = r_Latch;
  assign o_Error  = r_Error;
  assign o_Busy   = (r_State == S_HIGH) || (r_State == S_LOW) || (r_State == S_FORWARD);

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: directed WS2812 frames, expected colours queued
// at issue time and checked by an independent monitor on o_Valid.
module tb_ws2812_rx;

  logic        Clock;
  logic        Reset;
  logic        i_Din;
  logic [23:0] o_Colour;
  logic        o_Valid;
  logic        o_Dout;
  logic        o_Latch;
  logic        o_Error;
  logic        o_Busy;

  ws2812_rx dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .i_Din    (i_Din),
    .o_Colour (o_Colour),
    .o_Valid  (o_Valid),
    .o_Dout   (o_Dout),
    .o_Latch  (o_Latch),
    .o_Error  (o_Error),
    .o_Busy   (o_Busy)
  );

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int lastFall = 0;

  logic [23:0] expQ[$];
  int validCount = 0, lastValidCyc = -1;
  int latchCount = 0, lastLatchCyc = -1;
  int errCount   = 0, lastErrCyc   = -1;

  bit chkDout = 0;
  bit doutZero = 0;
  int doutChecks = 0, doutErrs = 0, doutNonZero = 0;
  logic dinH0 = 0, dinH1 = 0, dinH2 = 0;

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  // Cycle count and a three-deep history of the pin as seen at each rising edge
  initial begin
    forever begin
      @(posedge Clock);
      cyc++;
      dinH2 = dinH1;
      dinH1 = dinH0;
      dinH0 = i_Din;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every o_Valid and logs latch/error events
  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (o_Valid) begin
          validCount++;
          lastValidCyc = cyc;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", 32'(o_Colour), 32'hFFFF_FFFF);
          end else begin
            checkOutput("scoreboard_colour", 32'(o_Colour), 32'(expQ.pop_front()));
          end
        end
        if (o_Latch) begin
          latchCount++;
          lastLatchCyc = cyc;
        end
        if (o_Error) begin
          errCount++;
          lastErrCyc = cyc;
        end
        if (chkDout) begin
          doutChecks++;
          if (o_Dout !== dinH2) doutErrs++;
        end
        if (doutZero && o_Dout !== 1'b0) doutNonZero++;
      end
    end
  end

  task automatic sendBit(input logic b);
    i_Din = 1'b1;
    repeat (b ? 38 : 17) @(negedge Clock);
    i_Din = 1'b0;
    lastFall = cyc;
    repeat (b ? 22 : 43) @(negedge Clock);
  endtask

  task automatic sendBits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) sendBit(w[23-i]);
  endtask

  task automatic applyStimulus(input logic [23:0] w, input bit expectIt);
    if (expectIt) expQ.push_back(w);
    sendBits(w, 24);
  endtask

  task automatic holdLow(input int n);
    i_Din = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  int v0, l0, e0, fall, start;

  initial begin
    Reset = 1'b1;
    i_Din = 1'b0;
    repeat (5) @(negedge Clock);
    checkOutput("reset_colour", 32'(o_Colour), 32'h0);
    checkOutput("reset_valid", 32'(o_Valid), 32'h0);
    checkOutput("reset_dout", 32'(o_Dout), 32'h0);
    checkOutput("reset_latch", 32'(o_Latch), 32'h0);
    checkOutput("reset_error", 32'(o_Error), 32'h0);
    checkOutput("reset_busy", 32'(o_Busy), 32'h0);
    Reset = 1'b0;
    holdLow(2500);

    // Clean frame: colour, valid timing, latch timing, no forwarding
    $display("[TB] clean frame");
    v0 = validCount; l0 = latchCount; e0 = errCount;
    doutZero = 1;
    applyStimulus(24'hA50F3C, 1);
    fall = lastFall;
    holdLow(2500);
    doutZero = 0;
    checkOutput("t1_colour", 32'(o_Colour), 32'hA50F3C);
    checkOutput("t1_valid_count", 32'(validCount - v0), 32'd1);
    checkOutput("t1_valid_cycle", 32'(lastValidCyc), 32'(fall + 4));
    checkOutput("t1_latch_count", 32'(latchCount - l0), 32'd1);
    checkOutput("t1_latch_cycle", 32'(lastLatchCyc), 32'(fall + 2402));
    checkOutput("t1_error_count", 32'(errCount - e0), 32'd0);
    checkOutput("t1_dout_zero", 32'(doutNonZero), 32'd0);

    // Chain forward: second word appears on o_Dout three cycles late
    $display("[TB] chain forward");
    v0 = validCount; l0 = latchCount;
    applyStimulus(24'h123456, 1);
    chkDout = 1;
    applyStimulus(24'hFFFFFF, 0);
    holdLow(100);
    chkDout = 0;
    holdLow(2400);
    doutZero = 1;
    doutNonZero = 0;
    holdLow(20);
    doutZero = 0;
    checkOutput("t2_colour", 32'(o_Colour), 32'h123456);
    checkOutput("t2_valid_count", 32'(validCount - v0), 32'd1);
    checkOutput("t2_latch_count", 32'(latchCount - l0), 32'd1);
    checkOutput("t2_dout_checked", 32'(doutChecks > 1400), 32'd1);
    checkOutput("t2_dout_delay", 32'(doutErrs), 32'd0);
    checkOutput("t2_dout_after_latch", 32'(doutNonZero), 32'd0);

    // Glitch mid-word: error, rest of line ignored until a full gap
    $display("[TB] glitch");
    v0 = validCount; e0 = errCount;
    sendBits(24'hA50000, 8);
    i_Din = 1'b1;
    repeat (4) @(negedge Clock);
    i_Din = 1'b0;
    repeat (56) @(negedge Clock);
    sendBits(24'hFFF000, 12);
    holdLow(2500);
    checkOutput("t3_error_count", 32'(errCount - e0), 32'd1);
    checkOutput("t3_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("t3_colour_kept", 32'(o_Colour), 32'h123456);
    applyStimulus(24'h5A3C96, 1);
    holdLow(2500);
    checkOutput("t3_recover_colour", 32'(o_Colour), 32'h5A3C96);
    checkOutput("t3_recover_valid", 32'(validCount - v0), 32'd1);

    // Truncated word: error and latch together, colour unchanged
    $display("[TB] truncated word");
    v0 = validCount; l0 = latchCount; e0 = errCount;
    sendBits(24'h2B4000, 10);
    fall = lastFall;
    holdLow(2500);
    checkOutput("t4_error_count", 32'(errCount - e0), 32'd1);
    checkOutput("t4_latch_count", 32'(latchCount - l0), 32'd1);
    checkOutput("t4_err_with_latch", 32'(lastErrCyc), 32'(lastLatchCyc));
    checkOutput("t4_latch_cycle", 32'(lastLatchCyc), 32'(fall + 2402));
    checkOutput("t4_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("t4_colour_kept", 32'(o_Colour), 32'h5A3C96);

    // Stuck-high line
    $display("[TB] stuck high");
    e0 = errCount;
    start = cyc;
    i_Din = 1'b1;
    repeat (30) @(negedge Clock);
    checkOutput("t5_busy_during", 32'(o_Busy), 32'd1);
    checkOutput("t5_no_early_error", 32'(errCount - e0), 32'd0);
    repeat (70) @(negedge Clock);
    checkOutput("t5_busy_fell", 32'(o_Busy), 32'd0);
    checkOutput("t5_error_count", 32'(errCount - e0), 32'd1);
    checkOutput("t5_error_window", 32'((lastErrCyc - start >= 60) && (lastErrCyc - start <= 70)), 32'd1);
    holdLow(2500);

    // Reset during bit 12
    $display("[TB] reset mid-frame");
    sendBits(24'hC3A500, 11);
    i_Din = 1'b1;
    repeat (10) @(negedge Clock);
    Reset = 1'b1;
    #1;
    checkOutput("t6_colour", 32'(o_Colour), 32'h0);
    checkOutput("t6_valid", 32'(o_Valid), 32'h0);
    checkOutput("t6_dout", 32'(o_Dout), 32'h0);
    checkOutput("t6_latch", 32'(o_Latch), 32'h0);
    checkOutput("t6_error", 32'(o_Error), 32'h0);
    checkOutput("t6_busy", 32'(o_Busy), 32'h0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    v0 = validCount;
    repeat (28) @(negedge Clock);
    i_Din = 1'b0;
    repeat (22) @(negedge Clock);
    sendBits(24'hFFF000, 12);
    holdLow(2500);
    checkOutput("t6_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("t6_colour_cleared", 32'(o_Colour), 32'h0);
    applyStimulus(24'h0F0F0F, 1);
    holdLow(2500);
    checkOutput("t6_recover_colour", 32'(o_Colour), 32'h0F0F0F);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
